pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Parametrised successor to the single-pulse periodic generator.
- Produces a pulse train with programmable period, high-time (duty) and mode: free-running continuous, or a burst of a fixed number of periods followed by a done strobe.
- Sits between timing/control logic and peripherals that need PWM, strobes or bursts (LED drivers, bit-bang serial, sample triggers).
- Config is latched at start, so software may rewrite inputs while a train runs.

Parameters:
- N, 8, width of period/high-time counters (ticks, width).
- M, 8, width of burst length and pulse counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low: rst=0 forces reset state immediately.
- ena  in  1  count enable; when 0 all counters and out hold.
- start  in  1  single-cycle request to begin a train; sampled in IDLE only.
- stop  in  1  abort request; returns to IDLE next edge.
- mode  in  1  0 = continuous, 1 = burst.
- ticks  in  N  period in clk cycles (counted while ena=1); 0 treated as 1.
- width  in  N  high-time per period in cycles.
- burst_len  in  M  number of periods in burst mode.
- out  out  1  pulse output.
- busy  out  1  high in RUN.
- done  out  1  one-cycle strobe at burst completion.
- pulse_count  out  M  periods completed in current train (wraps at 2^M in continuous mode).

Behaviour:
- Reset (rst=0): state=IDLE; cnt=0; pulse_count=0; out=0, busy=0, done=0; latched config cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Transition on the edge where start=1 and stop=0.
  - That edge latches ticks_q = max(ticks,1), width_q, mode_q, len_q; clears cnt and pulse_count.
- IDLE, burst mode, burst_len=0: start goes directly IDLE -> DONE; no pulses emitted.
- RUN, per-edge counter update (only with ena=1):
  - cnt == ticks_q-1: cnt <= 0 and pulse_count <= pulse_count+1 (period boundary).
  - Otherwise cnt <= cnt+1.
  - ena=0: cnt, pulse_count and out hold.
- RUN, exits:
  - Burst mode, period boundary that makes pulse_count == len_q: go to DONE.
  - Continuous mode: stays in RUN until stop.
- out:
  - out = (state==RUN) && (cnt < width_q); combinational from registered state.
  - First high cycle is the cycle after the start edge (latency 1).
  - width_q=0: out never high.
  - width_q >= ticks_q: out constantly high while RUN.
  - ticks_q=1 with width_q>=1: out held high.
- DONE: done=1, busy=0, out=0 for exactly one cycle, then IDLE. pulse_count holds its final value until the next start.
- busy = (state==RUN).
- stop:
  - In RUN (any mode): next edge -> IDLE. out drops after that edge; no done strobe; pulse_count holds.
  - stop and start together in IDLE: stop wins, stay IDLE.
  - stop in DONE: ignored.
- start while RUN or DONE: ignored.
- Simultaneous stop with the final period boundary in burst mode: stop wins, IDLE, no done.
- Arithmetic: all counter increments are modulo 2^width; compare is unsigned.
- Async reset mid-train: outputs go to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: PULSE_TRAIN_RELOAD_EN.
- Defined:
  - ticks, width and mode are re-latched from the inputs at every period boundary in RUN.
  - Allows glitch-free duty/period changes on period edges; a new width never takes effect mid-period.
  - burst_len is still latched only at start.
- Undefined: config latched only at start, as described above.

Test Plan:
- Continuous, ticks=5, width=2, ena=1, start pulse -> out pattern 1,1,0,0,0 repeating from the cycle after start; pulse_count increments every 5 cycles; busy=1.
- Burst, ticks=4, width=1, burst_len=3 -> exactly 3 high cycles at 4-cycle spacing; done=1 for one cycle 12 cycles after start; pulse_count=3; then busy=0.
- ena toggled 1,0,0,1 during ticks=3, width=1 continuous -> cnt and out frozen during ena=0; period stretches by 2 cycles.
- Edge values: width=0 -> out stays 0; width=7, ticks=4 -> out stays 1; ticks=0 -> treated as 1; burst_len=0 -> done one cycle after start, no pulses.
- Burst, ticks=4, burst_len=5: stop at cycle 6, then start and stop together in IDLE -> IDLE next edge, out=0, no done, pulse_count=1 held, state stays IDLE.
- Drive rst=0 asynchronously mid-period -> out, busy, done, pulse_count go 0 without a clk edge. With PULSE_TRAIN_RELOAD_EN: change width 1->3 mid-period -> takes effect at the next boundary only.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//
// Programmable pulse-train generator. It runs either continuously or for a
// burst of a fixed number of periods. In burst mode a one-cycle done strobe
// follows the last period. Period, high-time, mode and burst length are
// captured on the start edge, so the inputs may change freely while a train
// is running.
//
// Optional feature: define PULSE_TRAIN_RELOAD_EN to re-capture ticks, width
// and mode at every period boundary while running. burst_len is still
// captured only at start. With this feature, duty and period changes take
// effect cleanly on a period edge and never part-way through a period.
//
// Parameters:
//   N  width of the period / high-time counters (ticks, width)
//   M  width of the burst length and the completed-period counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ena          count enable; counters and out hold while low
//   start        request to begin a train (honoured in IDLE only)
//   stop         abort; returns to IDLE on the next edge
//   mode         0 = continuous, 1 = burst
//   ticks        period in enabled clock cycles (0 behaves as 1)
//   width        high-time per period in enabled clock cycles
//   burst_len    number of periods in a burst
//   out          pulse output
//   busy         high while a train is running
//   done         one-cycle strobe when a burst completes
//   pulse_count  periods completed in the current train

module pulse_train_gen #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [N-1:0] ticks,
    input  logic [N-1:0] width,
    input  logic [M-1:0] burst_len,
    output logic         out,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] pulse_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [N-1:0] cnt;
    logic [N-1:0] ticks_q;
    logic [N-1:0] width_q;
    logic         mode_q;
    logic [M-1:0] len_q;

    logic [N-1:0] ticks_eff;
    logic         at_boundary;
    logic         load_cfg;
    logic         advance;
    logic [M-1:0] count_inc;

    // A zero period would never reach a boundary, so it runs as a one-cycle period.
    assign ticks_eff   = (ticks == '0) ? N'(1) : ticks;
    assign at_boundary = (cnt == ticks_q - N'(1));
    assign count_inc   = pulse_count + M'(1);

    // Stop takes priority over counting, so an abort on the final boundary
    // leaves pulse_count untouched.
    assign advance = (state == RUN) && !stop && ena;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load_cfg = 1'b1;
                    // An empty burst produces no pulses and goes straight to the done strobe.
                    if (mode && (burst_len == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (ena && at_boundary && mode_q && (count_inc == len_q)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out  = (state == RUN) && (cnt < width_q);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath: configuration capture, phase counter and period counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            pulse_count <= '0;
            ticks_q     <= '0;
            width_q     <= '0;
            mode_q      <= 1'b0;
            len_q       <= '0;
        end else if (load_cfg) begin
            cnt         <= '0;
            pulse_count <= '0;
            ticks_q     <= ticks_eff;
            width_q     <= width;
            mode_q      <= mode;
            len_q       <= burst_len;
        end else if (advance) begin
            if (at_boundary) begin
                cnt         <= '0;
                pulse_count <= count_inc;
`ifdef PULSE_TRAIN_RELOAD_EN
                ticks_q     <= ticks_eff;
                width_q     <= width;
                mode_q      <= mode;
`endif
            end else begin
                cnt <= cnt + N'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen.
// The table holds single-edge vectors with hand-computed outputs. The
// sequences after the table cover ena gating, aborts, asynchronous reset and
// the period-boundary reload behaviour.

module tb_pulse_train_gen;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] ticks;
    logic [7:0] width;
    logic [7:0] burst_len;
    logic       out;
    logic       busy;
    logic       done;
    logic [7:0] pulse_count;

    int total;
    int bad;

`ifdef PULSE_TRAIN_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    typedef struct {
        logic       ena;
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] ticks;
        logic [7:0] width;
        logic [7:0] len;
        logic       e_out;
        logic       e_busy;
        logic       e_done;
        logic [7:0] e_pc;
    } vector_t;

    vector_t vecs [0:63];
    int      n_vec;

    pulse_train_gen #(.N(8), .M(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .ticks       (ticks),
        .width       (width),
        .burst_len   (burst_len),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs, let one rising edge pass, settle just after it.
    task automatic applyStimulus(input logic i_ena, input logic i_start, input logic i_stop,
                                 input logic i_mode, input logic [7:0] i_ticks,
                                 input logic [7:0] i_width, input logic [7:0] i_len);
        ena       = i_ena;
        start     = i_start;
        stop      = i_stop;
        mode      = i_mode;
        ticks     = i_ticks;
        width     = i_width;
        burst_len = i_len;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_out, input logic e_busy,
                               input logic e_done, input logic [7:0] e_pc);
        total++;
        if ({out, busy, done, pulse_count} !== {e_out, e_busy, e_done, e_pc}) begin
            bad++;
            $display("[TB] FAIL %s: got out=%b busy=%b done=%b pc=%0d, want out=%b busy=%b done=%b pc=%0d",
                     name, out, busy, done, pulse_count, e_out, e_busy, e_done, e_pc);
        end
    endtask

    task automatic addVec(input logic i_ena, input logic i_start, input logic i_stop,
                          input logic i_mode, input logic [7:0] i_ticks,
                          input logic [7:0] i_width, input logic [7:0] i_len,
                          input logic e_out, input logic e_busy, input logic e_done,
                          input logic [7:0] e_pc);
        vecs[n_vec].ena    = i_ena;
        vecs[n_vec].start  = i_start;
        vecs[n_vec].stop   = i_stop;
        vecs[n_vec].mode   = i_mode;
        vecs[n_vec].ticks  = i_ticks;
        vecs[n_vec].width  = i_width;
        vecs[n_vec].len    = i_len;
        vecs[n_vec].e_out  = e_out;
        vecs[n_vec].e_busy = e_busy;
        vecs[n_vec].e_done = e_done;
        vecs[n_vec].e_pc   = e_pc;
        n_vec++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_vec = 0;

        // Continuous: ticks=5, width=2 -> 1,1,0,0,0 repeating; then stop
        addVec(1,1,0,0, 5,2,0, 1,1,0,0);
        addVec(1,0,0,0, 5,2,0, 1,1,0,0);
        addVec(1,0,0,0, 5,2,0, 0,1,0,0);
        addVec(1,0,0,0, 5,2,0, 0,1,0,0);
        addVec(1,0,0,0, 5,2,0, 0,1,0,0);
        addVec(1,0,0,0, 5,2,0, 1,1,0,1);
        addVec(1,0,0,0, 5,2,0, 1,1,0,1);
        addVec(1,0,0,0, 5,2,0, 0,1,0,1);
        addVec(1,0,0,0, 5,2,0, 0,1,0,1);
        addVec(1,0,0,0, 5,2,0, 0,1,0,1);
        addVec(1,0,0,0, 5,2,0, 1,1,0,2);
        addVec(1,0,1,0, 5,2,0, 0,0,0,2);
        // Burst: ticks=4, width=1, len=3; a start mid-run and one in DONE are ignored
        addVec(1,1,0,1, 4,1,3, 1,1,0,0);
        addVec(1,0,0,1, 4,1,3, 0,1,0,0);
        addVec(1,0,0,1, 4,1,3, 0,1,0,0);
        addVec(1,0,0,1, 4,1,3, 0,1,0,0);
        addVec(1,0,0,1, 4,1,3, 1,1,0,1);
        addVec(1,0,0,1, 4,1,3, 0,1,0,1);
        addVec(1,1,0,1, 4,1,3, 0,1,0,1);
        addVec(1,0,0,1, 4,1,3, 0,1,0,1);
        addVec(1,0,0,1, 4,1,3, 1,1,0,2);
        addVec(1,0,0,1, 4,1,3, 0,1,0,2);
        addVec(1,0,0,1, 4,1,3, 0,1,0,2);
        addVec(1,0,0,1, 4,1,3, 0,1,0,2);
        addVec(1,0,0,1, 4,1,3, 0,0,1,3);
        addVec(1,1,0,1, 4,1,3, 0,0,0,3);
        // width=0 never drives out high
        addVec(1,1,0,0, 3,0,0, 0,1,0,0);
        addVec(1,0,0,0, 3,0,0, 0,1,0,0);
        addVec(1,0,0,0, 3,0,0, 0,1,0,0);
        addVec(1,0,0,0, 3,0,0, 0,1,0,1);
        addVec(1,0,1,0, 3,0,0, 0,0,0,1);
        // width >= ticks keeps out high
        addVec(1,1,0,0, 4,7,0, 1,1,0,0);
        addVec(1,0,0,0, 4,7,0, 1,1,0,0);
        addVec(1,0,0,0, 4,7,0, 1,1,0,0);
        addVec(1,0,0,0, 4,7,0, 1,1,0,0);
        addVec(1,0,0,0, 4,7,0, 1,1,0,1);
        addVec(1,0,1,0, 4,7,0, 0,0,0,1);
        // ticks=0 behaves as a one-cycle period
        addVec(1,1,0,0, 0,1,0, 1,1,0,0);
        addVec(1,0,0,0, 0,1,0, 1,1,0,1);
        addVec(1,0,0,0, 0,1,0, 1,1,0,2);
        addVec(1,0,1,0, 0,1,0, 0,0,0,2);
        // Empty burst goes straight to DONE
        addVec(1,1,0,1, 4,2,0, 0,0,1,0);
        addVec(1,0,0,1, 4,2,0, 0,0,0,0);
        // start together with stop in IDLE: stop wins
        addVec(1,1,1,0, 5,2,0, 0,0,0,0);
        addVec(1,0,0,0, 5,2,0, 0,0,0,0);

        rst = 1'b0;
        ena = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        ticks = '0; width = '0; burst_len = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1,0,0,0, 5,2,0);
        checkOutput("idle_after_reset", 0, 0, 0, 0);

        for (int i = 0; i < n_vec; i++) begin
            applyStimulus(vecs[i].ena, vecs[i].start, vecs[i].stop, vecs[i].mode,
                          vecs[i].ticks, vecs[i].width, vecs[i].len);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].e_out, vecs[i].e_busy,
                        vecs[i].e_done, vecs[i].e_pc);
        end

        // ena 1,0,0,1: the period stretches by two cycles and out freezes
        applyStimulus(1,1,0,0, 3,1,0); checkOutput("ena_start", 1, 1, 0, 0);
        applyStimulus(0,0,0,0, 3,1,0); checkOutput("ena_hold1", 1, 1, 0, 0);
        applyStimulus(0,0,0,0, 3,1,0); checkOutput("ena_hold2", 1, 1, 0, 0);
        applyStimulus(1,0,0,0, 3,1,0); checkOutput("ena_resume", 0, 1, 0, 0);
        applyStimulus(1,0,0,0, 3,1,0); checkOutput("ena_cnt2", 0, 1, 0, 0);
        applyStimulus(1,0,0,0, 3,1,0); checkOutput("ena_stretched_boundary", 1, 1, 0, 1);
        applyStimulus(1,0,1,0, 3,1,0); checkOutput("ena_stop", 0, 0, 0, 1);

        // Burst ticks=4 len=5: stop at cycle 6, then start+stop together in IDLE
        applyStimulus(1,1,0,1, 4,2,5); checkOutput("abort_start", 1, 1, 0, 0);
        repeat (4) applyStimulus(1,0,0,1, 4,2,5);
        applyStimulus(1,0,0,1, 4,2,5); checkOutput("abort_pre_stop", 1, 1, 0, 1);
        applyStimulus(1,0,1,1, 4,2,5); checkOutput("abort_stop", 0, 0, 0, 1);
        applyStimulus(1,1,1,1, 4,2,5); checkOutput("abort_start_and_stop", 0, 0, 0, 1);
        applyStimulus(1,0,0,1, 4,2,5); checkOutput("abort_idle1", 0, 0, 0, 1);
        applyStimulus(1,0,0,1, 4,2,5); checkOutput("abort_idle2", 0, 0, 0, 1);

        // stop on the final burst boundary: stop wins, no done, count holds
        applyStimulus(1,1,0,1, 2,1,2); checkOutput("final_start", 1, 1, 0, 0);
        applyStimulus(1,0,0,1, 2,1,2); checkOutput("final_cnt1", 0, 1, 0, 0);
        applyStimulus(1,0,0,1, 2,1,2); checkOutput("final_first_boundary", 1, 1, 0, 1);
        applyStimulus(1,0,0,1, 2,1,2); checkOutput("final_cnt1b", 0, 1, 0, 1);
        applyStimulus(1,0,1,1, 2,1,2); checkOutput("final_stop_wins", 0, 0, 0, 1);
        applyStimulus(1,0,0,1, 2,1,2); checkOutput("final_no_done", 0, 0, 0, 1);

        // Asynchronous reset mid-period
        applyStimulus(1,1,0,0, 5,3,0);
        repeat (5) applyStimulus(1,0,0,0, 5,3,0);
        checkOutput("pre_async_reset", 1, 1, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1,0,0,0, 5,3,0); checkOutput("after_async_reset", 0, 0, 0, 0);

        // width changed 1->3 mid-period: never affects the current period
        applyStimulus(1,1,0,0, 4,1,0); checkOutput("reload_start", 1, 1, 0, 0);
        applyStimulus(1,0,0,0, 4,1,0); checkOutput("reload_cnt1", 0, 1, 0, 0);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_mid_period", 0, 1, 0, 0);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_cnt3", 0, 1, 0, 0);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_boundary", 1, 1, 0, 1);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_after_boundary1", RELOAD, 1, 0, 1);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_after_boundary2", RELOAD, 1, 0, 1);
        applyStimulus(1,0,0,0, 4,3,0); checkOutput("reload_cnt3b", 0, 1, 0, 1);
        applyStimulus(1,0,1,0, 4,3,0); checkOutput("reload_stop", 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
